// File: rtl/ex_mem_stage_pkg.sv
// Shared constants and slot-control decode for the EX/MEM pipeline register.
package ex_mem_stage_pkg;

   localparam logic        RstEnable    = 1'b1;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;
   localparam logic [4:0]  NOPRegAddr   = 5'b00000;
   localparam logic        WriteEnable  = 1'b1;
   localparam logic        WriteDisable = 1'b0;
   localparam logic [7:0]  EXE_NOP_OP   = 8'h00;

   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;

   typedef enum logic [1:0] {
      SLOT_HOLD,
      SLOT_ADVANCE,
      SLOT_BUBBLE,
      SLOT_FLUSH
   } slot_op_e;

   // stall_mem without stall_ex is illegal and resolves to a hold
   function automatic slot_op_e slot_op(
      input logic flush,
      input logic stall_ex,
      input logic stall_mem
   );
      if (flush)
         return SLOT_FLUSH;
      else if (stall_ex && !stall_mem)
         return SLOT_BUBBLE;
      else if (!stall_ex && !stall_mem)
         return SLOT_ADVANCE;
      else
         return SLOT_HOLD;
   endfunction

endpackage

// File: rtl/ex_mem_stage_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr)
         q <= '0;
      else if (inc && (q != {W{1'b1}}))
         q <= q + W'(1);
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with stall, flush, bubble insertion and
// multi-cycle accumulator feedback to EX.
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int OPW  = 8,
   parameter int CNTW = 2,
   parameter int BUBW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_ex,
   input  logic            stall_mem,
   input  logic            flush,
   input  logic [AW-1:0]   ex_wd,
   input  logic            ex_wreg,
   input  logic [DW-1:0]   ex_wdata,
   input  logic [DW-1:0]   ex_hi,
   input  logic [DW-1:0]   ex_lo,
   input  logic            ex_whilo,
   input  logic [OPW-1:0]  ex_aluop,
   input  logic [DW-1:0]   ex_mem_addr,
   input  logic [DW-1:0]   ex_reg2,
   input  logic [2*DW-1:0] hilo_i,
   input  logic [CNTW-1:0] cnt_i,
   output logic [AW-1:0]   mem_wd,
   output logic            mem_wreg,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW-1:0]   mem_hi,
   output logic [DW-1:0]   mem_lo,
   output logic            mem_whilo,
   output logic [OPW-1:0]  mem_aluop,
   output logic [DW-1:0]   mem_mem_addr,
   output logic [DW-1:0]   mem_reg2,
   output logic            mem_valid,
   output logic [2*DW-1:0] hilo_o,
   output logic [CNTW-1:0] cnt_o,
   output logic [BUBW-1:0] bubble_cnt
);

   slot_op_e op;
   logic     illegal_stall;

   assign op            = slot_op(flush, stall_ex, stall_mem);
   assign illegal_stall = stall_mem && !stall_ex;

   always_ff @(posedge clk) begin
      if (rst == RstEnable || op == SLOT_FLUSH || op == SLOT_BUBBLE) begin
         mem_wd       <= AW'(NOPRegAddr);
         mem_wreg     <= WriteDisable;
         mem_wdata    <= DW'(ZeroWord);
         mem_hi       <= DW'(ZeroWord);
         mem_lo       <= DW'(ZeroWord);
         mem_whilo    <= WriteDisable;
         mem_aluop    <= OPW'(EXE_NOP_OP);
         mem_mem_addr <= DW'(ZeroWord);
         mem_reg2     <= DW'(ZeroWord);
         mem_valid    <= 1'b0;
      end else if (op == SLOT_ADVANCE) begin
         mem_wd       <= ex_wd;
         mem_wreg     <= ex_wreg;
         mem_wdata    <= ex_wdata;
         mem_hi       <= ex_hi;
         mem_lo       <= ex_lo;
         mem_whilo    <= ex_whilo;
         mem_aluop    <= ex_aluop;
         mem_mem_addr <= ex_mem_addr;
         mem_reg2     <= ex_reg2;
         mem_valid    <= 1'b1;
      end
   end

   // accumulator survives bubbles, is consumed on advance
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         hilo_o <= '0;
         cnt_o  <= '0;
      end else begin
         unique case (op)
            SLOT_FLUSH, SLOT_ADVANCE: begin
               hilo_o <= '0;
               cnt_o  <= '0;
            end
            SLOT_BUBBLE: begin
               hilo_o <= hilo_i;
               cnt_o  <= cnt_i;
            end
            SLOT_HOLD: begin
               hilo_o <= hilo_o;
               cnt_o  <= cnt_o;
            end
         endcase
      end
   end

   sat_counter #(.W(BUBW)) u_bub (
      .clk (clk),
      .clr (rst == RstEnable),
      .inc (op == SLOT_BUBBLE),
      .q   (bubble_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst != RstEnable)
         assert (!illegal_stall)
         else $warning("ex_mem_stage: stall_mem raised without stall_ex");
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, pass-through, bubble, hold,
// flush, saturation and illegal stall.
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst, stall_ex, stall_mem, flush;
   logic [4:0]  ex_wd;
   logic        ex_wreg, ex_whilo;
   logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
   logic [7:0]  ex_aluop;
   logic [63:0] hilo_i;
   logic [1:0]  cnt_i;

   logic [4:0]  mem_wd, mem_wd4;
   logic        mem_wreg, mem_whilo, mem_valid;
   logic        mem_wreg4, mem_whilo4, mem_valid4;
   logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
   logic [31:0] mem_wdata4, mem_hi4, mem_lo4, mem_mem_addr4, mem_reg24;
   logic [7:0]  mem_aluop, mem_aluop4;
   logic [63:0] hilo_o, hilo_o4;
   logic [1:0]  cnt_o, cnt_o4;
   logic [15:0] bubble_cnt;
   logic [3:0]  bubble_cnt4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem),
      .flush(flush), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ex_aluop(ex_aluop),
      .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .hilo_i(hilo_i),
      .cnt_i(cnt_i), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
      .mem_wdata(mem_wdata), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
      .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
      .mem_valid(mem_valid), .hilo_o(hilo_o), .cnt_o(cnt_o),
      .bubble_cnt(bubble_cnt)
   );

   ex_mem_stage #(.BUBW(4)) dut4 (
      .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem),
      .flush(flush), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ex_aluop(ex_aluop),
      .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .hilo_i(hilo_i),
      .cnt_i(cnt_i), .mem_wd(mem_wd4), .mem_wreg(mem_wreg4),
      .mem_wdata(mem_wdata4), .mem_hi(mem_hi4), .mem_lo(mem_lo4),
      .mem_whilo(mem_whilo4), .mem_aluop(mem_aluop4),
      .mem_mem_addr(mem_mem_addr4), .mem_reg2(mem_reg24),
      .mem_valid(mem_valid4), .hilo_o(hilo_o4), .cnt_o(cnt_o4),
      .bubble_cnt(bubble_cnt4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall_ex = 1'b0; stall_mem = 1'b0; flush = 1'b0;
      ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'h1111_2222;
      ex_hi = 32'h3; ex_lo = 32'h4; ex_whilo = 1'b1; ex_aluop = 8'h23;
      ex_mem_addr = 32'h100; ex_reg2 = 32'h200;
      hilo_i = 64'h5; cnt_i = 2'd2;
      tick(); tick();
      checks++;
      if (mem_wd !== 5'd0 || mem_wreg !== 1'b0 || mem_wdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_wr: wd=%0d wreg=%b wdata=%h need 0",
                  mem_wd, mem_wreg, mem_wdata);
      end
      checks++;
      if (mem_hi !== 32'd0 || mem_lo !== 32'd0 || mem_whilo !== 1'b0 ||
          mem_aluop !== 8'd0 || mem_mem_addr !== 32'd0 ||
          mem_reg2 !== 32'd0 || mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_misc: hi=%h lo=%h whilo=%b op=%h addr=%h r2=%h v=%b need 0",
                  mem_hi, mem_lo, mem_whilo, mem_aluop, mem_mem_addr,
                  mem_reg2, mem_valid);
      end
      checks++;
      if (hilo_o !== 64'd0 || cnt_o !== 2'd0 || bubble_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_acc: hilo=%h cnt=%0d bub=%0d need 0",
                  hilo_o, cnt_o, bubble_cnt);
      end
   endtask

   task automatic test_pass_through();
      rst = 1'b0;
      ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF;
      ex_hi = 32'hA5A5_0001; ex_lo = 32'h5A5A_0002; ex_whilo = 1'b1;
      ex_aluop = 8'h2C; ex_mem_addr = 32'h8000_0010; ex_reg2 = 32'hCAFE_F00D;
      tick();
      checks++;
      if (mem_wd !== 5'd5 || mem_wreg !== 1'b1 ||
          mem_wdata !== 32'hDEAD_BEEF || mem_valid !== 1'b1) begin
         errors++;
         $display("FAIL pass_wr: wd=%0d wreg=%b wdata=%h v=%b need 5 1 deadbeef 1",
                  mem_wd, mem_wreg, mem_wdata, mem_valid);
      end
      checks++;
      if (mem_hi !== 32'hA5A5_0001 || mem_lo !== 32'h5A5A_0002 ||
          mem_whilo !== 1'b1) begin
         errors++;
         $display("FAIL pass_hilo: hi=%h lo=%h whilo=%b need a5a50001 5a5a0002 1",
                  mem_hi, mem_lo, mem_whilo);
      end
      checks++;
      if (mem_aluop !== 8'h2C || mem_mem_addr !== 32'h8000_0010 ||
          mem_reg2 !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL pass_ls: op=%h addr=%h r2=%h need 2c 80000010 cafef00d",
                  mem_aluop, mem_mem_addr, mem_reg2);
      end
   endtask

   task automatic test_bubble();
      stall_ex = 1'b1; stall_mem = 1'b0;
      hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
      tick(); tick();
      checks++;
      if (mem_wreg !== 1'b0 || mem_valid !== 1'b0 || mem_wd !== 5'd0 ||
          mem_wdata !== 32'd0) begin
         errors++;
         $display("FAIL bubble_nop: wreg=%b v=%b wd=%0d wdata=%h need 0",
                  mem_wreg, mem_valid, mem_wd, mem_wdata);
      end
      checks++;
      if (hilo_o !== 64'h0000_0001_0000_0002 || cnt_o !== 2'd1) begin
         errors++;
         $display("FAIL bubble_acc: hilo=%h cnt=%0d need 0000000100000002 1",
                  hilo_o, cnt_o);
      end
      checks++;
      if (bubble_cnt !== 16'd2) begin
         errors++;
         $display("FAIL bubble_cnt: got %0d need 2", bubble_cnt);
      end
      stall_ex = 1'b0;
      tick();
      checks++;
      if (hilo_o !== 64'd0 || cnt_o !== 2'd0 || mem_valid !== 1'b1) begin
         errors++;
         $display("FAIL bubble_consume: hilo=%h cnt=%0d v=%b need 0 0 1",
                  hilo_o, cnt_o, mem_valid);
      end
   endtask

   task automatic test_hold();
      ex_wdata = 32'h1234_5678; ex_wd = 5'd12;
      tick();
      stall_ex = 1'b1; stall_mem = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ex_wdata = 32'hFFFF_0000 ^ 32'(i);
         ex_wd = 5'(i + 20);
         hilo_i = 64'(i + 77);
         tick();
         checks++;
         if (mem_wdata !== 32'h1234_5678 || mem_wd !== 5'd12 ||
             mem_valid !== 1'b1 || bubble_cnt !== 16'd2 ||
             hilo_o !== 64'd0) begin
            errors++;
            $display("FAIL hold_%0d: wdata=%h wd=%0d v=%b bub=%0d hilo=%h need 12345678 12 1 2 0",
                     i, mem_wdata, mem_wd, mem_valid, bubble_cnt, hilo_o);
         end
      end
   endtask

   task automatic test_flush();
      flush = 1'b1; stall_ex = 1'b1; stall_mem = 1'b0;
      hilo_i = 64'h0000_00AB_0000_00CD; cnt_i = 2'd3;
      tick();
      checks++;
      if (mem_wd !== 5'd0 || mem_wdata !== 32'd0 || mem_wreg !== 1'b0 ||
          mem_valid !== 1'b0 || mem_aluop !== 8'd0 ||
          mem_mem_addr !== 32'd0) begin
         errors++;
         $display("FAIL flush_mem: wd=%0d wdata=%h wreg=%b v=%b op=%h addr=%h need 0",
                  mem_wd, mem_wdata, mem_wreg, mem_valid, mem_aluop,
                  mem_mem_addr);
      end
      checks++;
      if (hilo_o !== 64'd0 || cnt_o !== 2'd0 || bubble_cnt !== 16'd2) begin
         errors++;
         $display("FAIL flush_acc: hilo=%h cnt=%0d bub=%0d need 0 0 2",
                  hilo_o, cnt_o, bubble_cnt);
      end
      flush = 1'b0; stall_ex = 1'b0;
   endtask

   task automatic test_illegal_stall();
      ex_wd = 5'd7; ex_wdata = 32'hAAAA_5555;
      tick();
      stall_ex = 1'b0; stall_mem = 1'b1;
      ex_wd = 5'd30; ex_wdata = 32'h0BAD_0BAD;
      #1;
      checks++;
      if (dut.illegal_stall !== 1'b1) begin
         errors++;
         $display("FAIL illegal_flag: got %b need 1", dut.illegal_stall);
      end
      tick();
      checks++;
      if (mem_wd !== 5'd7 || mem_wdata !== 32'hAAAA_5555 ||
          mem_valid !== 1'b1 || bubble_cnt !== 16'd2) begin
         errors++;
         $display("FAIL illegal_hold: wd=%0d wdata=%h v=%b bub=%0d need 7 aaaa5555 1 2",
                  mem_wd, mem_wdata, mem_valid, bubble_cnt);
      end
      stall_mem = 1'b0;
   endtask

   task automatic test_saturation();
      rst = 1'b1;
      tick();
      rst = 1'b0; stall_ex = 1'b1; stall_mem = 1'b0;
      hilo_i = 64'h0000_0002_0000_0003; cnt_i = 2'd2;
      for (int i = 0; i < 20; i++) tick();
      checks++;
      if (bubble_cnt4 !== 4'd15) begin
         errors++;
         $display("FAIL sat_reach: got %0d need 15", bubble_cnt4);
      end
      tick();
      checks++;
      if (bubble_cnt4 !== 4'd15 || bubble_cnt !== 16'd21) begin
         errors++;
         $display("FAIL sat_stay: bub4=%0d bub16=%0d need 15 21",
                  bubble_cnt4, bubble_cnt);
      end
      checks++;
      if (hilo_o !== 64'h0000_0002_0000_0003 || cnt_o !== 2'd2) begin
         errors++;
         $display("FAIL sat_acc: hilo=%h cnt=%0d need 0000000200000003 2",
                  hilo_o, cnt_o);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (bubble_cnt4 !== 4'd0 || bubble_cnt !== 16'd0 ||
          hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
         errors++;
         $display("FAIL sat_reset: bub4=%0d bub16=%0d hilo=%h cnt=%0d need 0",
                  bubble_cnt4, bubble_cnt, hilo_o, cnt_o);
      end
      rst = 1'b0; stall_ex = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_bubble();
      test_hold();
      test_flush();
      test_illegal_stall();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
